// File: rtl/pixel_sink.sv
// pixel_sink: buffers pixel-write requests, converts (x,y) to framebuffer addresses and runs the screen clear.
// Define PIXEL_SINK_CLIP_EN to discard off-screen pixels and count them in dropped_count.
module pixel_sink #(
  parameter int unsigned SCREEN_W   = 160,
  parameter int unsigned SCREEN_H   = 120,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned ADDR_W     = 15,
  parameter logic [2:0]  BG_COLOR   = 3'b000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic [2:0]        color,
  input  logic              plot,
  output logic              ready,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [2:0]        fb_data,
  output logic              fb_we,
  output logic [15:0]       dropped_count
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned NPIX  = SCREEN_W * SCREEN_H;
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(NPIX - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic [2:0] color;
  } pix_t;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_CLEAR} state_t;

  state_t             state, state_nxt;
  pix_t               mem [FIFO_DEPTH];
  pix_t               head;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count, count_nxt;
  logic [ADDR_W-1:0]  clr_cnt;
  logic [ADDR_W-1:0]  addr_calc;
  logic               clr_pend;
  logic               accept, push, pop;
  logic               we_d, busy_d;
  logic [ADDR_W-1:0]  addr_d;
  logic [2:0]         data_d;

  assign ready  = (count != CNT_FULL);
  assign accept = plot && ready;
  assign pop    = (state == S_WRITE) && (count != '0);

`ifdef PIXEL_SINK_CLIP_EN
  logic in_bounds;
  logic drop;

  assign in_bounds = (x < 10'(SCREEN_W)) && (y < 10'(SCREEN_H));
  assign push      = accept && in_bounds;
  assign drop      = accept && !in_bounds;

  // Saturating count of off-screen pixels that completed the handshake
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dropped_count <= '0;
    end else if (drop && (dropped_count != 16'hFFFF)) begin
      dropped_count <= dropped_count + 16'd1;
    end
  end
`else
  assign push          = accept;
  assign dropped_count = '0;
`endif

  assign count_nxt = count + CNT_W'(push) - CNT_W'(pop);
  assign head      = mem[rd_ptr];
  assign addr_calc = ADDR_W'(32'(head.y) * 32'(SCREEN_W) + 32'(head.x));

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{x: x, y: y, color: color};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
    end
  end

  // Clear request is held until the FSM enters S_CLEAR; requests during a clear are ignored
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clr_pend <= 1'b0;
    end else if ((state != S_CLEAR) && (state_nxt == S_CLEAR)) begin
      clr_pend <= 1'b0;
    end else if (clear_req && (state != S_CLEAR)) begin
      clr_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clr_cnt <= '0;
    end else if (state == S_CLEAR) begin
      clr_cnt <= clr_cnt + ADDR_W'(1);
    end else begin
      clr_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (clr_pend) begin
          state_nxt = S_CLEAR;
        end else if (count != '0) begin
          state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        if (clr_pend) begin
          state_nxt = S_CLEAR;
        end else if (count_nxt == '0) begin
          state_nxt = S_IDLE;
        end
      end
      S_CLEAR: begin
        if (clr_cnt == CLR_LAST) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Write-port values for the next edge; address/data hold when no write is issued
  always_comb begin
    we_d   = 1'b0;
    addr_d = fb_addr;
    data_d = fb_data;
    busy_d = (state_nxt == S_CLEAR);
    case (state)
      S_WRITE: begin
        if (pop) begin
          we_d   = 1'b1;
          addr_d = addr_calc;
          data_d = head.color;
        end
      end
      S_CLEAR: begin
        we_d   = 1'b1;
        addr_d = clr_cnt;
        data_d = BG_COLOR;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fb_we      <= 1'b0;
      fb_addr    <= '0;
      fb_data    <= '0;
      clear_busy <= 1'b0;
    end else begin
      fb_we      <= we_d;
      fb_addr    <= addr_d;
      fb_data    <= data_d;
      clear_busy <= busy_d;
    end
  end

endmodule
